// File: rtl/online_otf_converter_if.sv
// Handshake bundle for the online radix-4 to two's-complement converter.
// The digit stream enters on the in_* signals and completed words leave on the out_* signals.
interface online_otf_converter_if #(
  parameter int WIDTH = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_digit;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH:0]  out_data;
  logic              out_err;

  modport master (
    output in_valid, in_digit, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_digit, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/online_otf_converter.sv
// On-the-fly conversion of MSD-first radix-4 signed digits (-3..+3) into a two's-complement word.
// Optional illegal-digit (3'b100) flagging is enabled by defining OTFC_DIGIT_CHECK_EN.
module online_otf_converter #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  online_otf_converter_if.slave  bus
);
  localparam int DW = 2*WIDTH + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next, base_cnt;
  logic [DW-1:0]   q, qm, q_next, qm_next;
  logic [DW-1:0]   base_q, base_qm, digit_ext;
  logic            accept, word_xfer, first;
  logic            digit_nonneg, digit_pos;

  assign bus.in_ready  = (state == ACCUM) || bus.out_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = (state == HOLD) ? q : '0;

  assign accept    = bus.in_valid && bus.in_ready;
  assign word_xfer = (state == HOLD) && bus.out_ready;
  // A digit accepted in HOLD starts a fresh word, just like the first digit in ACCUM.
  assign first     = (state == HOLD) || (cnt == '0);
  assign base_cnt  = (state == HOLD) ? '0 : cnt;
  assign base_q    = first ? '0 : q;
  assign base_qm   = first ? '1 : qm;

  assign digit_ext    = {{(DW-3){bus.in_digit[2]}}, bus.in_digit};
  assign digit_nonneg = !bus.in_digit[2];
  assign digit_pos    = !bus.in_digit[2] && (bus.in_digit[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      cnt   <= '0;
      q     <= '0;
      qm    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      q     <= q_next;
      qm    <= qm_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    q_next     = q;
    qm_next    = qm;
    if (word_xfer && !accept) begin
      state_next = ACCUM;
      cnt_next   = '0;
    end
    if (accept) begin
      // Q tracks the value so far; QM tracks value-1, so a negative digit never needs a borrow chain.
      if (digit_nonneg)
        q_next = {base_q[DW-3:0], 2'b00} + digit_ext;
      else
        q_next = {base_qm[DW-3:0], 2'b00} + digit_ext + DW'(4);
      if (digit_pos)
        qm_next = {base_q[DW-3:0], 2'b00} + digit_ext - DW'(1);
      else
        qm_next = {base_qm[DW-3:0], 2'b00} + digit_ext + DW'(3);
      if (base_cnt == CW'(WIDTH-1)) begin
        state_next = HOLD;
        cnt_next   = '0;
      end else begin
        state_next = ACCUM;
        cnt_next   = base_cnt + CW'(1);
      end
    end
  end

`ifdef OTFC_DIGIT_CHECK_EN
  logic err, err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else
      err <= err_next;
  end

  always_comb begin
    err_next = err;
    if (word_xfer && !accept)
      err_next = 1'b0;
    if (accept)
      err_next = (first ? 1'b0 : err) | (bus.in_digit == 3'b100);
  end

  assign bus.out_err = (state == HOLD) && err;
`else
  assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_online_otf_converter.sv
// Directed and randomized checks of online_otf_converter (WIDTH=2) against a word-level model.
// Illegal-digit flag expectations follow OTFC_DIGIT_CHECK_EN.
module tb_online_otf_converter;
  localparam int W  = 2;
  localparam int DW = 2*W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   words  = 0;

  online_otf_converter_if #(.WIDTH(W)) bus ();

  online_otf_converter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word-level model: digits collected so far and the word awaiting delivery.
  int            digs[$];
  bit            pend = 1'b0;
  logic [DW-1:0] pend_data = '0;
  bit            pend_err = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", DW'(bus.out_valid), DW'(pend));
    chk("in_ready", DW'(bus.in_ready), DW'(!pend || bus.out_ready));
    if (pend) begin
      chk("out_data", bus.out_data, pend_data);
      chk("out_err", DW'(bus.out_err), DW'(pend_err));
    end
  endtask

  task automatic model_update();
    bit  ir, wx, dx;
    ir = !pend || bus.out_ready;
    wx = pend && bus.out_ready;
    dx = bus.in_valid && ir;
    if (wx) begin
      $display("word %0d: data=%0d err=%0b", words, $signed(pend_data), pend_err);
      words++;
      pend = 1'b0;
    end
    if (dx) begin
      digs.push_back(int'($signed(bus.in_digit)));
      if (digs.size() == W) begin
        longint val = 0;
        bit     bad = 1'b0;
        foreach (digs[k]) begin
          val = val*4 + digs[k];
          if (digs[k] == -4) bad = 1'b1;
        end
        pend_data = val[DW-1:0];
`ifdef OTFC_DIGIT_CHECK_EN
        pend_err = bad;
`else
        pend_err = 1'b0;
`endif
        pend = 1'b1;
        digs.delete();
      end
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase one cycle later.
  task automatic cycle(input logic v, input logic [2:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_digit  = d;
    bus.out_ready = r;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    digs.delete();
    pend = 1'b0;
    #1;
    chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
    chk("rst_out_data", bus.out_data, DW'(0));
    chk("rst_out_err", DW'(bus.out_err), DW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", DW'(bus.in_ready), DW'(1));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_digit  = 3'b000;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    cycle(1'b0, 3'd0, 1'b0);

    // [+1,-1] -> 3
    cycle(1'b1, 3'b001, 1'b1);
    cycle(1'b1, 3'b111, 1'b1);
    cycle(1'b0, 3'd0, 1'b1);
    cycle(1'b0, 3'd0, 1'b1);

    // [-3,-3] then [+3,+3] back to back -> -15, 15
    cycle(1'b1, 3'b101, 1'b1);
    cycle(1'b1, 3'b101, 1'b1);
    cycle(1'b1, 3'b011, 1'b1);
    cycle(1'b1, 3'b011, 1'b1);
    cycle(1'b0, 3'd0, 1'b1);

    // [0,0] held for 5 cycles with a digit waiting
    cycle(1'b1, 3'b000, 1'b0);
    cycle(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'b010, 1'b0);
    cycle(1'b0, 3'd0, 1'b1);
    cycle(1'b0, 3'd0, 1'b1);

    // reset mid-word, then [+2,+1] -> 9
    cycle(1'b1, 3'b010, 1'b1);
    do_reset();
    cycle(1'b0, 3'd0, 1'b1);
    cycle(1'b1, 3'b010, 1'b1);
    cycle(1'b1, 3'b001, 1'b1);
    cycle(1'b0, 3'd0, 1'b1);

    // [-4,0] -> -16 (flagged when checking is enabled), then [0,+1] -> 1
    cycle(1'b1, 3'b100, 1'b0);
    cycle(1'b1, 3'b000, 1'b0);
    cycle(1'b0, 3'd0, 1'b0);
    cycle(1'b1, 3'b000, 1'b1);
    cycle(1'b1, 3'b001, 1'b1);
    cycle(1'b0, 3'd0, 1'b1);

    // reset while holding a word
    cycle(1'b1, 3'b011, 1'b0);
    cycle(1'b1, 3'b010, 1'b0);
    cycle(1'b0, 3'd0, 1'b0);
    do_reset();
    cycle(1'b0, 3'd0, 1'b1);

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
